// File: rtl/freq_meter_pkg.sv
// Shared types and board constants for the gated frequency meter.
// FREQ_METER_AUTO_RESTART_EN (in freq_meter.sv) selects continuous measurement.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } fm_state_e;

    // Board clock, shared with the clock-divider path.
    localparam int unsigned BOARD_CLK_HZ = 50_000_000;

    localparam int unsigned DEF_GATE_CYCLES = BOARD_CLK_HZ;
    localparam int unsigned DEF_CNT_W       = 26;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
// A clean input edge sampled on clock edge b shows up as rise during the cycle after edge b+SYNC_STAGES-1.
module sig_sync_edge
    import freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk50M,
    input  logic Reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk50M or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clk50M cycles.
// Define FREQ_METER_AUTO_RESTART_EN for continuous back-to-back windows after the first start.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk50M,
    input  logic             Reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] freq_count,
    output logic             overflow
);

    localparam int unsigned         GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    fm_state_e         state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  freq_count_q, freq_count_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              rise;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk50M   (clk50M),
        .Reset    (Reset),
        .async_in (sig_in),
        .rise     (rise)
    );

    always_ff @(posedge clk50M or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            freq_count_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            ovf_q        <= ovf_d;
            freq_count_q <= freq_count_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        ovf_d        = ovf_q;
        freq_count_d = freq_count_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end

            GATE: begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                // A full counter holds its value; the lost edge is what overflow reports.
                if (rise) begin
                    if (edge_cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
                // Result registers load on entry to LATCH so they are already valid while done is high.
                if (gate_cnt_q == GATE_LAST) begin
                    state_d      = LATCH;
                    freq_count_d = edge_cnt_d;
                    overflow_d   = ovf_d;
                    done_d       = 1'b1;
                end
            end

            LATCH: begin
`ifdef FREQ_METER_AUTO_RESTART_EN
                state_d    = GATE;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
`else
                state_d    = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == GATE);
    assign done       = done_q;
    assign freq_count = freq_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (CNT_W=8 and CNT_W=5) share stimulus,
// results are compared against an edge-history model of the gate window.
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int LAT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_in;
    logic       start;
    logic       busy8, done8, ovf8;
    logic [7:0] cnt8;
    logic       busy5, done5, ovf5;
    logic [4:0] cnt5;

    int n_checks = 0;
    int n_fail   = 0;

    bit hist[$];
    int cur;
    int sig_mode;
    int sig_per;
    int ph;
    int exp_c8, exp_o8, exp_c5, exp_o5;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk50M(clk), .Reset(rst), .sig_in(sig_in), .start(start),
        .busy(busy8), .done(done8), .freq_count(cnt8), .overflow(ovf8)
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(5), .SYNC_STAGES(2)) dut5 (
        .clk50M(clk), .Reset(rst), .sig_in(sig_in), .start(start),
        .busy(busy5), .done(done5), .freq_count(cnt5), .overflow(ovf5)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive the next sig_in value, advance one clock, record what the DUT sampled.
    task automatic step();
        case (sig_mode)
            0:       sig_in = 1'b0;
            1:       sig_in = ((ph % sig_per) < (sig_per / 2));
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
        ph++;
        @(posedge clk);
        hist.push_back(sig_in);
        cur = hist.size() - 1;
        #1;
    endtask

    // Rising edges sampled on edge b become countable LAT edges later; the window
    // counts on clock edges e0+1 .. e0+GATE.
    function automatic int raw_rises(input int e0);
        int n = 0;
        for (int b = e0 + 1 - LAT; b <= e0 + GATE - LAT; b++) begin
            if (hist[b] && !hist[b-1]) n++;
        end
        return n;
    endfunction

    task automatic run_idle(input int n, input string tag);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done8 || busy8 || done5 || busy5) act++;
        end
        check_eq({tag, "_quiet"}, act, 0);
        check_eq({tag, "_cnt8_held"}, cnt8, exp_c8);
    endtask

    task automatic run_window(input bit do_start, input bit mid_start, input string tag);
        int e0;
        int done_at = -1;
        int busy_n  = 0;
        int raw;
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        e0 = cur;
        for (int k = 0; k < GATE + 5; k++) begin
            if (done8) begin
                done_at = cur;
                break;
            end
            if (busy8) busy_n++;
            if (k == GATE / 2) begin
                check_eq({tag, "_hold_cnt8"}, cnt8, exp_c8);
                check_eq({tag, "_hold_cnt5"}, cnt5, exp_c5);
            end
            start = mid_start && (k == GATE / 2 - 10);
            step();
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, (done_at >= 0), 1);
        if (done_at < 0) return;
        check_eq({tag, "_latency"}, done_at - e0, GATE);
        check_eq({tag, "_busy_cycles"}, busy_n, GATE);
        check_eq({tag, "_done5"}, done5, 1);
        raw    = raw_rises(e0);
        exp_c8 = (raw > 255) ? 255 : raw;
        exp_o8 = (raw > 255) ? 1 : 0;
        exp_c5 = (raw > 31) ? 31 : raw;
        exp_o5 = (raw > 31) ? 1 : 0;
        check_eq({tag, "_cnt8"}, cnt8, exp_c8);
        check_eq({tag, "_ovf8"}, ovf8, exp_o8);
        check_eq({tag, "_cnt5"}, cnt5, exp_c5);
        check_eq({tag, "_ovf5"}, ovf5, exp_o5);
        step();
        check_eq({tag, "_done_pulse"}, done8, 0);
`ifdef FREQ_METER_AUTO_RESTART_EN
        check_eq({tag, "_busy_restart"}, busy8, 1);
`else
        check_eq({tag, "_busy_after"}, busy8, 0);
`endif
    endtask

    task automatic reset_phase();
        rst      = 1'b1;
        start    = 1'b0;
        sig_mode = 2;
        repeat (5) step();
        check_eq("rst_busy", busy8, 0);
        check_eq("rst_done", done8, 0);
        check_eq("rst_cnt8", cnt8, 0);
        check_eq("rst_ovf8", ovf8, 0);
        check_eq("rst_cnt5", cnt5, 0);
        rst    = 1'b0;
        exp_c8 = 0; exp_o8 = 0; exp_c5 = 0; exp_o5 = 0;
        run_idle(20, "post_rst");
    endtask

    task automatic abort_test();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy8, 0);
        check_eq("abort_done", done8, 0);
        check_eq("abort_cnt8", cnt8, 0);
        check_eq("abort_ovf8", ovf8, 0);
        check_eq("abort_cnt5", cnt5, 0);
        check_eq("abort_ovf5", ovf5, 0);
        exp_c8 = 0; exp_o8 = 0; exp_c5 = 0; exp_o5 = 0;
        repeat (3) step();
        rst = 1'b0;
        run_idle(GATE + 10, "abort_idle");
    endtask

    initial begin
        sig_in = 1'b0;
        ph     = 0;
        sig_per = 2;
        reset_phase();

`ifdef FREQ_METER_AUTO_RESTART_EN
        sig_mode = 1; sig_per = 4; ph = int'($urandom_range(0, 99));
        run_window(1, 1, "auto0");
        check_eq("auto0_spec", cnt8, 25);
        for (int w = 1; w < 3; w++) begin
            run_window(0, 1, "auto_p4");
            check_eq("auto_p4_spec", cnt8, 25);
        end
        sig_mode = 2;
        run_window(0, 0, "auto_rand0");
        run_window(0, 1, "auto_rand1");
        sig_mode = 1; sig_per = 2;
        repeat (10) step();
        abort_test();
        sig_mode = 1; sig_per = 10; ph = int'($urandom_range(0, 99));
        run_window(1, 0, "auto_after");
`else
        sig_mode = 1; sig_per = 10; ph = int'($urandom_range(0, 99));
        run_window(1, 0, "p10");
        check_eq("p10_spec", cnt8, 10);
        run_idle(5, "p10_idle");

        sig_mode = 0;
        run_window(1, 1, "zero");
        check_eq("zero_spec", cnt8, 0);
        run_idle(GATE + 10, "no_second_done");

        sig_mode = 1; sig_per = 2; ph = int'($urandom_range(0, 99));
        run_window(1, 0, "p2");
        check_eq("p2_sat5", cnt5, 31);
        check_eq("p2_ovf5", ovf5, 1);
        run_idle(3, "p2_idle");

        abort_test();
        sig_mode = 1; sig_per = 10; ph = int'($urandom_range(0, 99));
        run_window(1, 0, "after_abort");

        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                sig_mode = 2;
            end else begin
                sig_mode = 1;
                sig_per  = int'($urandom_range(2, 16));
                ph       = int'($urandom_range(0, 99));
            end
            run_window(1, 1'($urandom_range(0, 1)), "rand");
            run_idle(int'($urandom_range(1, 5)), "rand_idle");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
